// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: digit ordering, active-low
// seven-segment glyphs and the decimal-point pattern that forms HH.MM.SS.
package stopwatch_pkg;

   localparam int NUM_DIGITS = 6;

   typedef logic [3:0] bcd_t;
   typedef bcd_t [NUM_DIGITS-1:0] digits_t;

   // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b010100;

   localparam logic [2:0] IDX_SEC_ONES = 3'd0;
   localparam logic [2:0] IDX_SEC_TENS = 3'd1;
   localparam logic [2:0] IDX_MIN_ONES = 3'd2;
   localparam logic [2:0] IDX_MIN_TENS = 3'd3;
   localparam logic [2:0] IDX_HR_ONES  = 3'd4;
   localparam logic [2:0] IDX_HR_TENS  = 3'd5;

   function automatic logic [NUM_DIGITS-1:0] anode_select_n(input logic [2:0] idx);
      return ~(NUM_DIGITS'(1) << idx);
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment glyph; non-decimal codes show a dash.
module bcd_to_seg7 (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   import stopwatch_pkg::*;

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes six BCD stopwatch digits onto a common-anode display, with
// lap freeze, leading-zero hour blanking and an all-off guard at each digit switch.
module seg7_scan_driver #(
   parameter int DIGIT_PERIOD  = 100_000,
   parameter int GUARD_CYCLES  = 16,
   parameter int BLANK_LEADING = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sec_ones,
   input  logic [3:0] sec_tens,
   input  logic [3:0] min_ones,
   input  logic [3:0] min_tens,
   input  logic [3:0] hr_ones,
   input  logic [3:0] hr_tens,
   input  logic       lap,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frozen
);
   import stopwatch_pkg::*;

   localparam int CNT_W = $clog2(DIGIT_PERIOD);

   logic [CNT_W-1:0] slot_cnt;
   logic [2:0]       idx;
   digits_t          port_digits;
   digits_t          live_q;
   digits_t          snap_q;
   digits_t          src;
   logic [6:0]       glyph;
   logic             blank;
   logic [5:0]       an_d;
   logic [6:0]       seg_d;
   logic             dp_d;

   always_comb begin
      port_digits               = '0;
      port_digits[IDX_SEC_ONES] = sec_ones;
      port_digits[IDX_SEC_TENS] = sec_tens;
      port_digits[IDX_MIN_ONES] = min_ones;
      port_digits[IDX_MIN_TENS] = min_tens;
      port_digits[IDX_HR_ONES]  = hr_ones;
      port_digits[IDX_HR_TENS]  = hr_tens;
   end

   assign src = frozen ? snap_q : live_q;

   bcd_to_seg7 u_decode (
      .bcd (src[idx]),
      .seg (glyph)
   );

   // NOTE: every output gets a default before any condition, so no path can hold an old value (no latch).
   always_comb begin
      blank = 1'b0;
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (BLANK_LEADING != 0) begin
         if (idx == IDX_HR_TENS && src[IDX_HR_TENS] == 4'd0)
            blank = 1'b1;
         if (idx == IDX_HR_ONES && src[IDX_HR_TENS] == 4'd0 && src[IDX_HR_ONES] == 4'd0)
            blank = 1'b1;
      end
      // Anode stays driven on a blanked digit so the dp can still light
      if (slot_cnt >= CNT_W'(GUARD_CYCLES)) begin
         an_d  = anode_select_n(idx);
         seg_d = blank ? SEG_OFF : glyph;
         dp_d  = ~DP_MASK[idx];
      end
   end

   // NOTE: state uses <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         slot_cnt <= '0;
         idx      <= IDX_SEC_ONES;
         live_q   <= '0;
         // NOTE: the snapshot is a handful of flops whose value is visible after reset, so it is cleared like all other state.
         snap_q   <= '0;
         frozen   <= 1'b0;
         an       <= '1;
         seg      <= SEG_OFF;
         dp       <= 1'b1;
      end else begin
         live_q <= port_digits;
         if (slot_cnt == CNT_W'(DIGIT_PERIOD - 1)) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_HR_TENS) ? IDX_SEC_ONES : idx + 3'd1;
         end else begin
            slot_cnt <= slot_cnt + CNT_W'(1);
         end
         // Snapshot takes the port values of the lap cycle itself, not the live stage
         if (lap) begin
            frozen <= ~frozen;
            if (!frozen)
               snap_q <= port_digits;
         end
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the stopwatch counter block: takes the six BCD digits (HH MM SS) and time-multiplexes them onto a 6-digit common-anode seven-segment display.
- Adds a lap freeze (display snapshot while counting continues), leading-zero blanking of hours, and anti-ghosting guard time at digit switches.
- Runs on the 100 MHz board clock.

Parameters:
- DIGIT_PERIOD, 100_000, clock cycles each digit is selected (1 ms at 100 MHz; 6 ms full refresh). Must be greater than GUARD_CYCLES+1.
- GUARD_CYCLES, 16, cycles at the start of each digit slot with all anodes off (anti-ghosting).
- BLANK_LEADING, 1, 1 = blank leading zero hour digits; 0 = always show all six digits.

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- sec_ones  in  4  BCD seconds units
- sec_tens  in  4  BCD seconds tens
- min_ones  in  4  BCD minutes units
- min_tens  in  4  BCD minutes tens
- hr_ones  in  4  BCD hours units
- hr_tens  in  4  BCD hours tens
- lap  in  1  single-cycle pulse; toggles freeze mode
- an  out  6  digit anodes, active-low; an[0] = rightmost digit (sec_ones), an[5] = hr_tens
- seg  out  7  segments, active-low; seg[0]=a ... seg[6]=g
- dp  out  1  decimal point, active-low
- frozen  out  1  1 while the display shows the lap snapshot

Behaviour:
- Interface: single clock domain (clk). reset is synchronous and active-high; all state is sampled on posedge clk.
- Reset values:
  - an = 6'b111111, seg = 7'b1111111, dp = 1, frozen = 0.
  - slot counter = 0, digit index = 0, snapshot registers = 0.
- Slot counter: counts 0..DIGIT_PERIOD-1.
  - At DIGIT_PERIOD-1 it wraps to 0, and the digit index advances 0→1→...→5→0.
- Source select:
  - frozen=0: the display source is the input ports registered one cycle (live stage).
  - frozen=1: the display source is the snapshot registers.
- Lap:
  - On a cycle with lap=1, frozen toggles.
  - On a 0→1 toggle, the snapshot captures the input port values present in that same cycle.
  - On a 1→0 toggle, the display returns to live data on the next cycle; the snapshot is left unchanged.
  - Back-to-back lap pulses toggle on each pulse.
  - Lap coinciding with a slot wrap: both take effect on the same edge.
- Outputs are registered:
  - an, seg and dp reflect the slot counter, index and source from the previous cycle.
  - Latency from an input port change to seg is 2 cycles (input register + output register) when the digit is displayed and outside the guard window.
- Guard window: while the slot counter < GUARD_CYCLES, the outputs are an = 6'b111111, seg = all off, dp = 1.
  - Otherwise an has exactly one bit low: an[index] = 0.
- Decode:
  - Values 0–9 map to standard glyphs.
  - Values 10–15 (invalid BCD) show a dash (only g lit: seg = 7'b0111111).
- Blanking (BLANK_LEADING=1), evaluated on the selected source:
  - index 5 is blanked (seg all off, anode still driven) when hr_tens==0.
  - index 4 is blanked when hr_tens==0 and hr_ones==0.
  - Minute and second digits are never blanked.
- Decimal points: dp=0 on index 2 (min_ones) and index 4 (hr_ones), producing HH.MM.SS.
  - dp is shown regardless of blanking; it is off (1) on all other indices.
- Reset mid-operation: all state returns to reset values on the next edge, including frozen and the snapshot.
  - A lap pulse in the same cycle as reset is ignored.

Decomposition:
- Shared package stopwatch_pkg:
  - NUM_DIGITS = 6
  - segment glyph constants SEG_0..SEG_9, SEG_DASH, SEG_OFF (active-low 7-bit)
  - DP_MASK = 6'b010100
  - digit index constants IDX_SEC_ONES..IDX_HR_TENS
- Sub-module bcd_to_seg7: combinational 4-bit BCD to 7-bit active-low glyph, with the dash for values above 9.

Test Plan:
1. Bench parameters DIGIT_PERIOD=8, GUARD_CYCLES=2. Release reset, inputs 12:34:56 → an cycles 111110, 111101, ..., 011111, each low for 6 of 8 cycles, all-ones for 2. seg per slot = 6,5,4,3,2,1 glyphs; dp low only in slots 2 and 4.
2. Inputs 00:07:09 with BLANK_LEADING=1 → slots 4 and 5 show seg=1111111 with the anode still low. dp is still low in slot 4. Slot 0 shows glyph 9.
3. Inputs 00:00:05, lap pulse, then inputs change to 00:00:08 → frozen=1 and slot 0 keeps showing 5. A second lap pulse → frozen=0, and slot 0 shows 8 two cycles later.
4. sec_ones=4'hB → slot 0 seg = 7'b0111111 (dash). Other digits are unaffected.
5. Reset asserted mid-slot 3 while frozen → next cycle an=111111, seg=1111111, dp=1, frozen=0. The scan restarts at index 0 with slot counter 0.
6. Lap pulse on the slot wrap cycle (index 2→3) → the snapshot holds that cycle's inputs, frozen=1, and the index advances normally with no skipped or repeated slot.
